// File: rtl/cfg_readback_tx.sv
// Configuration readback transmitter: streams config RAM words to the host as MSB-first nibbles.
// Optional CRC-8 trailer is compiled in when CFG_READBACK_CRC_EN is defined.
module cfg_readback_tx #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [3:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int NIBS   = WORD_W / 4;
  localparam int NIB_CW = $clog2(NIBS + 1);

  localparam logic [NIB_CW-1:0] NIB_ONE  = NIB_CW'(1);
  localparam logic [NIB_CW-1:0] NIB_LOAD = NIB_CW'(NIBS);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_CRC_HI,
    S_CRC_LO,
    S_DONE
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   shift_q;   // nibbles still to be presented after the current tx_data
  logic [NIB_CW-1:0]   nib_cnt;
  logic [ADDR_W:0]     word_cnt;
  logic [ADDR_W:0]     len_q;

  logic hs;
  logic last_nib;
  logic last_word;

  assign hs        = tx_valid && tx_ready;
  assign last_nib  = (nib_cnt == NIB_ONE);
  assign last_word = (word_cnt == (len_q - CNT_ONE));

`ifdef CFG_READBACK_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_next;

  // CRC-8 poly 0x07, fed MSB first one bit at a time.
  function automatic logic [7:0] crc8_nibble(input logic [7:0] crc, input logic [3:0] nib);
    logic [7:0] c;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      if (c[7] ^ nib[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else               c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_next = crc8_nibble(crc_q, tx_data);

  always_ff @(posedge clk) begin
    if (rst)                           crc_q <= 8'h00;
    else if (state == S_IDLE && start) crc_q <= 8'h00;
    else if (state == S_SEND && hs)    crc_q <= crc_next;
  end
`endif

  // NOTE: all state here is registered with non-blocking assignments so every
  // branch sees the pre-edge values; blocking would leak updates between outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      tx_data   <= 4'h0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_q   <= '0;
      nib_cnt   <= '0;
      word_cnt  <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            len_q    <= len;
            word_cnt <= '0;
            mem_addr <= base_addr;
            if (len != '0) begin
              mem_rd_en <= 1'b1;
              state     <= S_READ;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_READ: begin
          mem_rd_en <= 1'b0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          tx_data  <= mem_rdata[WORD_W-1 -: 4];
          shift_q  <= mem_rdata << 4;
          nib_cnt  <= NIB_LOAD;
          tx_valid <= 1'b1;
          state    <= S_SEND;
        end

        S_SEND: begin
          if (hs) begin
            tx_data <= shift_q[WORD_W-1 -: 4];
            shift_q <= shift_q << 4;
            nib_cnt <= nib_cnt - NIB_ONE;
            if (last_nib) begin
              if (!last_word) begin
                tx_valid  <= 1'b0;
                word_cnt  <= word_cnt + CNT_ONE;
                mem_addr  <= mem_addr + ADDR_ONE;
                mem_rd_en <= 1'b1;
                state     <= S_READ;
              end else begin
`ifdef CFG_READBACK_CRC_EN
                tx_data <= crc_next[7:4];
                state   <= S_CRC_HI;
`else
                tx_valid <= 1'b0;
                done     <= 1'b1;
                state    <= S_DONE;
`endif
              end
            end
          end
        end

`ifdef CFG_READBACK_CRC_EN
        S_CRC_HI: begin
          if (hs) begin
            tx_data <= crc_q[3:0];
            state   <= S_CRC_LO;
          end
        end

        S_CRC_LO: begin
          if (hs) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          mem_rd_en <= 1'b0;
          tx_valid  <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_readback_tx.sv
// Directed bench for cfg_readback_tx with a synchronous RAM model and address/nibble scoreboards.
// Expected CRC trailer nibbles are added when CFG_READBACK_CRC_EN is defined.
module tb_cfg_readback_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  len;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [3:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [15:0] ram [64];
  logic [5:0]  exp_addr [$];
  logic [3:0]  exp_nib [$];

  int n_checks = 0;
  int n_fail   = 0;
  bit rd_seen;
  bit valid_seen;

`ifdef CFG_READBACK_CRC_EN
  localparam int CRC_NIBS = 2;
`else
  localparam int CRC_NIBS = 0;
`endif

  cfg_readback_tx #(.WORD_W(16), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [3:0] nib);
    logic [7:0] r;
    r = c;
    for (int b = 3; b >= 0; b--) r = (r << 1) ^ ((r[7] ^ nib[b]) ? 8'h07 : 8'h00);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshake about to happen, then sample #1 after the edge.
  task automatic tick();
    logic       held;
    logic [3:0] held_data;
    held      = tx_valid && !tx_ready && !rst;
    held_data = tx_data;
    if (tx_valid && tx_ready && !rst) begin
      check("extra_nibble", 32'(exp_nib.size() != 0), 32'd1);
      if (exp_nib.size() != 0) check("nibble", 32'(tx_data), 32'(exp_nib.pop_front()));
    end
    @(posedge clk);
    #1;
    if (held) begin
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(held_data));
    end
    if (mem_rd_en) begin
      rd_seen = 1'b1;
      check("extra_read", 32'(exp_addr.size() != 0), 32'd1);
      if (exp_addr.size() != 0) check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
    if (tx_valid) valid_seen = 1'b1;
  endtask

  task automatic expect_xfer(input logic [5:0] b, input int n);
    logic [7:0] crc;
    logic [5:0] a;
    logic [3:0] nib;
    crc = 8'h00;
    for (int w = 0; w < n; w++) begin
      a = 6'(int'(b) + w);
      exp_addr.push_back(a);
      for (int k = 3; k >= 0; k--) begin
        nib = ram[a][4*k +: 4];
        exp_nib.push_back(nib);
        crc = crc_upd(crc, nib);
      end
    end
`ifdef CFG_READBACK_CRC_EN
    exp_nib.push_back(crc[7:4]);
    exp_nib.push_back(crc[3:0]);
`endif
  endtask

  task automatic do_start(input logic [5:0] b, input logic [6:0] l);
    start     = 1'b1;
    base_addr = b;
    len       = l;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < max);
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_idle_queues(input string tag);
    check({tag, "_nib_q"}, 32'(exp_nib.size()), 32'd0);
    check({tag, "_addr_q"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] pat;

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; tx_ready = 1'b1;
    for (int i = 0; i < 64; i++) ram[i] = 16'(i * 16'h0101);
    ram[5]  = 16'hA3C1;
    ram[63] = 16'h1234;
    ram[0]  = 16'h5678;
    ram[10] = 16'h9E5B;
    ram[11] = 16'hF00D;
    ram[20] = 16'h4D2F;
    ram[40] = 16'h1357;
    ram[41] = 16'h2468;
    ram[50] = 16'h0001;

    repeat (2) tick();
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Single word, exact latency.
    expect_xfer(6'd5, 1);
    do_start(6'd5, 7'd1);
    check("t1_rd_en", 32'(mem_rd_en), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_wait_valid", 32'(tx_valid), 32'd0);
    tick();
    check("t1_first_valid", 32'(tx_valid), 32'd1);
    check("t1_first_nib", 32'(tx_data), 32'hA);
    run_until_done(50, n);
    check("t1_done_cycle", 32'(n), 32'(4 + CRC_NIBS));
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check_idle_queues("t1");

    // Address wrap 63 -> 0, 2-cycle inter-word gap.
    expect_xfer(6'd63, 2);
    do_start(6'd63, 7'd2);
    run_until_done(50, n);
    check("t2_done_cycle", 32'(n), 32'(12 + CRC_NIBS));
    tick();
    check_idle_queues("t2");

    // Backpressure pattern 1,0,0,1 repeating.
    pat = 4'b1001;
    expect_xfer(6'd10, 2);
    do_start(6'd10, 7'd2);
    for (int k = 0; k < 200 && !done; k++) begin
      tx_ready = pat[k % 4];
      tick();
    end
    check("t3_done_seen", 32'(done), 32'd1);
    tx_ready = 1'b1;
    tick();
    check_idle_queues("t3");

    // Zero length.
    rd_seen = 1'b0; valid_seen = 1'b0;
    do_start(6'd7, 7'd0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    tick();
    check("t4_done_fall", 32'(done), 32'd0);
    check("t4_busy_fall", 32'(busy), 32'd0);
    check("t4_no_read", 32'(rd_seen), 32'd0);
    check("t4_no_valid", 32'(valid_seen), 32'd0);

    // Start while busy is ignored.
    expect_xfer(6'd20, 1);
    do_start(6'd20, 7'd1);
    repeat (3) tick();
    start = 1'b1; base_addr = 6'd30; len = 7'd3;
    tick();
    start = 1'b0;
    run_until_done(50, n);
    repeat (3) tick();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(tx_valid), 32'd0);
    check_idle_queues("t5");

    // Reset in SEND after two nibbles, then restart elsewhere.
    expect_xfer(6'd40, 1);
    do_start(6'd40, 7'd1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("t6_rd_en", 32'(mem_rd_en), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_tx_data", 32'(tx_data), 32'd0);
    check("t6_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_remaining", 32'(exp_nib.size()), 32'(2 + CRC_NIBS));
    rst = 1'b0;
    exp_nib.delete();
    tick();
    check("t6_no_done", 32'(done), 32'd0);
    expect_xfer(6'd41, 1);
    do_start(6'd41, 7'd1);
    run_until_done(50, n);
    check("t6_restart_cycle", 32'(n), 32'(6 + CRC_NIBS));
    tick();
    check_idle_queues("t6");

`ifdef CFG_READBACK_CRC_EN
    // Known CRC vector: 0x0001 -> CRC 0x07.
    exp_addr.push_back(6'd50);
    exp_nib.push_back(4'h0); exp_nib.push_back(4'h0);
    exp_nib.push_back(4'h0); exp_nib.push_back(4'h1);
    exp_nib.push_back(4'h0); exp_nib.push_back(4'h7);
    do_start(6'd50, 7'd1);
    run_until_done(50, n);
    check("t7_done_cycle", 32'(n), 32'd8);
    tick();
    check_idle_queues("t7");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
